// File: rtl/icache_fetch_if.sv
// Fetch-side and memory-side handshake bundles of the instruction cache.
// On the fetch bundle the instruction unit is master; on the memory bundle the cache is master.
interface icache_fetch_if;
  logic [31:0] pc_in;
  logic        inst_req;
  logic        inst_ready;
  logic [31:0] inst;
  logic        mem_busy;

  modport master (output pc_in, inst_req, input inst_ready, inst, mem_busy);
  modport slave  (input pc_in, inst_req, output inst_ready, inst, mem_busy);
endinterface

interface icache_mem_if;
  logic        mem_req;
  logic        mem_grant;
  logic [31:0] mem_addr;
  logic [7:0]  mem_byte;

  modport master (output mem_req, mem_addr, input mem_grant, mem_byte);
  modport slave  (input mem_req, mem_addr, output mem_grant, mem_byte);
endinterface

// File: rtl/icache_fetch.sv
// Direct-mapped read-only instruction cache, one word per line, filled a byte
// at a time through a granted arbiter port. Hits are answered combinationally.
module icache_fetch #(
  parameter int INDEX_BIT = 8,
  parameter int TAG_BIT   = 30 - INDEX_BIT
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rdy_in,
  input  logic           clear,
  icache_fetch_if.slave  fetch,
  icache_mem_if.master   mem
);
  localparam int LINES = 1 << INDEX_BIT;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, FETCH} state_t;

  logic [LINES-1:0]   valid;
  logic [TAG_BIT-1:0] tag_arr  [LINES];
  logic [31:0]        data_arr [LINES];

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] fill_base;
  logic [23:0] line_buf;
  logic        busy_q, req_q;

  logic [INDEX_BIT-1:0] idx, fidx;
  logic [TAG_BIT-1:0]   tag, ftag;
  logic                 hit, line_we;
  logic                 unused_pc_lsb;

  assign idx  = fetch.pc_in[INDEX_BIT+1:2];
  assign tag  = fetch.pc_in[31:INDEX_BIT+2];
  assign fidx = fill_base[INDEX_BIT+1:2];
  assign ftag = fill_base[31:INDEX_BIT+2];
  assign unused_pc_lsb = ^fetch.pc_in[1:0];

  assign hit = valid[idx] && (tag_arr[idx] == tag);

  assign fetch.inst_ready = fetch.inst_req && hit && (state == IDLE);
  assign fetch.inst       = data_arr[idx];
  assign fetch.mem_busy   = busy_q;
  assign mem.mem_req      = req_q;
  assign mem.mem_addr     = (state == FETCH && cnt < 3'd4) ? fill_base + {29'b0, cnt} : 32'b0;

  // Last fetch cycle: the final byte arrives and the whole line is committed.
  assign line_we = !rst_in && rdy_in && (state == FETCH) && (cnt == 3'd4);

  always_ff @(posedge clk_in) begin
    if (line_we) begin
      data_arr[fidx] <= {mem.mem_byte, line_buf};
      tag_arr[fidx]  <= ftag;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      fill_base <= 32'b0;
      line_buf  <= 24'b0;
      valid     <= '0;
      busy_q    <= 1'b0;
      req_q     <= 1'b0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (fetch.inst_req && !hit && !clear) begin
            fill_base <= {fetch.pc_in[31:2], 2'b00};
            state     <= WAIT_GRANT;
            busy_q    <= 1'b1;
            req_q     <= 1'b1;
          end
        end
        WAIT_GRANT: begin
          if (clear) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            req_q  <= 1'b0;
          end else if (mem.mem_grant) begin
            state <= FETCH;
            cnt   <= 3'd0;
          end
        end
        FETCH: begin
          // Byte returned now belongs to the address driven last cycle; clear
          // is ignored since the line being read is still correct.
          case (cnt)
            3'd1: line_buf[7:0]   <= mem.mem_byte;
            3'd2: line_buf[15:8]  <= mem.mem_byte;
            3'd3: line_buf[23:16] <= mem.mem_byte;
            default: ;
          endcase
          if (cnt == 3'd4) begin
            valid[fidx] <= 1'b1;
            cnt         <= 3'd0;
            state       <= IDLE;
            busy_q      <= 1'b0;
            req_q       <= 1'b0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          req_q  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_icache_fetch.sv
// Directed bench for icache_fetch: cold miss, hit, eviction, clear, pause, reset.
module tb_icache_fetch;
  logic clk_in = 1'b0;
  logic rst_in, rdy_in, clear;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk_in = ~clk_in;

  icache_fetch_if fetch ();
  icache_mem_if   mem ();

  icache_fetch #(.INDEX_BIT(8)) dut (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .clear  (clear),
    .fetch  (fetch),
    .mem    (mem)
  );

  // Byte-wide memory: returns the byte for last cycle's address, paused with rdy_in.
  logic [7:0] mem_arr [0:2047];
  always @(posedge clk_in)
    if (rdy_in) mem.mem_byte <= mem_arr[mem.mem_addr[10:0]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) mem_arr[a+i] = w[8*i +: 8];
  endtask

  // Called in the miss cycle with grant held high and the request held.
  task automatic fill_run(input string tag, input logic [31:0] base, input logic [31:0] word);
    tick();
    chk({tag, "_wg_req"},  {31'b0, mem.mem_req},    32'd1);
    chk({tag, "_wg_busy"}, {31'b0, fetch.mem_busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk({tag, "_addr"}, mem.mem_addr, base + i);
    end
    tick();
    chk({tag, "_addr_cnt4"}, mem.mem_addr, 32'h0);
    tick();
    chk({tag, "_hit_rdy"}, {31'b0, fetch.inst_ready}, 32'd1);
    chk({tag, "_inst"},    fetch.inst,                word);
    chk({tag, "_req_off"}, {31'b0, mem.mem_req},      32'd0);
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem_arr[i] = 8'h00;
    put_word(32'h000, 32'h0000_0013);
    put_word(32'h400, 32'hDEAD_BEEF);
    put_word(32'h010, 32'hCAFE_F00D);
    put_word(32'h020, 32'h1234_5678);
    put_word(32'h030, 32'hA5B6_C7D8);
    put_word(32'h040, 32'h0BAD_C0DE);

    rst_in = 1'b1; rdy_in = 1'b1; clear = 1'b0;
    mem.mem_grant = 1'b0; fetch.inst_req = 1'b0; fetch.pc_in = 32'h0;
    tick(); tick();
    chk("rst_req",  {31'b0, mem.mem_req},    32'd0);
    chk("rst_busy", {31'b0, fetch.mem_busy}, 32'd0);
    chk("rst_addr", mem.mem_addr,            32'h0);
    rst_in = 1'b0;
    tick();
    chk("idle_rdy",  {31'b0, fetch.inst_ready}, 32'd0);
    chk("idle_busy", {31'b0, fetch.mem_busy},   32'd0);

    // Cold miss at 0x0
    mem.mem_grant = 1'b1; fetch.pc_in = 32'h0; fetch.inst_req = 1'b1;
    #1;
    chk("cold_miss_rdy", {31'b0, fetch.inst_ready}, 32'd0);
    chk("cold_miss_req", {31'b0, mem.mem_req},      32'd0);
    fill_run("cold", 32'h0, 32'h0000_0013);

    // Hit after fill, no memory traffic
    tick();
    chk("hit_rdy",  {31'b0, fetch.inst_ready}, 32'd1);
    chk("hit_inst", fetch.inst,                32'h0000_0013);
    chk("hit_req",  {31'b0, mem.mem_req},      32'd0);

    // Conflict eviction: 0x400 shares index 0 with 0x0
    fetch.pc_in = 32'h400; #1;
    chk("evict_miss", {31'b0, fetch.inst_ready}, 32'd0);
    fill_run("evict", 32'h400, 32'hDEAD_BEEF);
    fetch.pc_in = 32'h0; #1;
    chk("refill_miss", {31'b0, fetch.inst_ready}, 32'd0);
    fill_run("refill", 32'h0, 32'h0000_0013);

    // Grant held off, then clear aborts the miss
    mem.mem_grant = 1'b0; fetch.pc_in = 32'h10; #1;
    tick();
    chk("wg_busy", {31'b0, fetch.mem_busy}, 32'd1);
    tick(); tick();
    chk("wg_hold_busy", {31'b0, fetch.mem_busy}, 32'd1);
    chk("wg_hold_addr", mem.mem_addr,            32'h0);
    clear = 1'b1; fetch.inst_req = 1'b0;
    tick();
    chk("abort_busy", {31'b0, fetch.mem_busy}, 32'd0);
    chk("abort_req",  {31'b0, mem.mem_req},    32'd0);
    clear = 1'b0; fetch.inst_req = 1'b1; #1;
    chk("abort_line_invalid", {31'b0, fetch.inst_ready}, 32'd0);
    mem.mem_grant = 1'b1;
    fill_run("line4", 32'h10, 32'hCAFE_F00D);

    // Clear during FETCH is ignored
    fetch.pc_in = 32'h20; #1;
    tick();
    tick(); chk("clrf_addr0", mem.mem_addr, 32'h20);
    tick(); chk("clrf_addr1", mem.mem_addr, 32'h21);
    clear = 1'b1;
    tick();
    chk("clrf_busy",  {31'b0, fetch.mem_busy}, 32'd1);
    chk("clrf_addr2", mem.mem_addr,            32'h22);
    clear = 1'b0;
    tick(); chk("clrf_addr3", mem.mem_addr, 32'h23);
    tick();
    tick();
    chk("clrf_hit_rdy", {31'b0, fetch.inst_ready}, 32'd1);
    chk("clrf_inst",    fetch.inst,                32'h1234_5678);

    // Pause for two cycles at cnt==2
    fetch.pc_in = 32'h30; #1;
    tick(); tick(); tick();
    tick(); chk("pause_addr2", mem.mem_addr, 32'h32);
    rdy_in = 1'b0;
    tick(); chk("pause_hold1", mem.mem_addr, 32'h32);
    tick(); chk("pause_hold2", mem.mem_addr, 32'h32);
    chk("pause_busy", {31'b0, fetch.mem_busy}, 32'd1);
    rdy_in = 1'b1;
    tick(); chk("pause_addr3", mem.mem_addr, 32'h33);
    tick();
    tick();
    chk("pause_hit_rdy", {31'b0, fetch.inst_ready}, 32'd1);
    chk("pause_inst",    fetch.inst,                32'hA5B6_C7D8);

    // Reset in the middle of a fill
    fetch.pc_in = 32'h40; #1;
    tick(); tick(); tick();
    rst_in = 1'b1;
    tick();
    chk("mrst_req",  {31'b0, mem.mem_req},    32'd0);
    chk("mrst_busy", {31'b0, fetch.mem_busy}, 32'd0);
    chk("mrst_addr", mem.mem_addr,            32'h0);
    rst_in = 1'b0; fetch.inst_req = 1'b0;
    tick();
    fetch.inst_req = 1'b1; fetch.pc_in = 32'h0; #1;
    chk("mrst_inv0",  {31'b0, fetch.inst_ready}, 32'd0);
    fetch.pc_in = 32'h20; #1;
    chk("mrst_inv20", {31'b0, fetch.inst_ready}, 32'd0);
    fill_run("postrst", 32'h20, 32'h1234_5678);

    fetch.inst_req = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
